// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: master mode codes, FSM
// state encoding and default timing parameters.
package i2c_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 24000;
  localparam int GUARD_CYCLES_DEFAULT   = 4;

  typedef enum logic [7:0] {
    I2C_Wait           = 8'h00,
    I2C_Write          = 8'h01,
    I2C_Write_Cont     = 8'h02,
    I2C_Write_Directly = 8'h03,
    I2C_Read           = 8'h04,
    I2C_Read_Cont      = 8'h05,
    I2C_Read_Directly  = 8'h06
  } i2c_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } arb_state_e;

  function automatic logic mode_valid(input logic [7:0] m);
    return (m >= I2C_Write) && (m <= I2C_Read_Directly);
  endfunction

  function automatic logic mode_is_read(input logic [7:0] m);
    return (m >= I2C_Read) && (m <= I2C_Read_Directly);
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and master-core signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the surrounding system's view.
interface i2c_req_arbiter_if;
  logic [1:0] req;
  logic [7:0] mode0, mode1;
  logic [6:0] dev0, dev1;
  logic [7:0] reg0, reg1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] i2c_config;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_reg_data;
  logic       i2c_xfer_done;
  logic [7:0] i2c_read_data;

  // Handshake: req is a level held until its done pulse; gnt is one-hot while
  // the transfer is in flight; done is a one-cycle pulse carrying err/rdata.
  modport slave (
    input  req, mode0, mode1, dev0, dev1, reg0, reg1, wdata0, wdata1,
    input  i2c_xfer_done, i2c_read_data,
    output gnt, done, err, rdata, busy,
    output i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data
  );

  modport master (
    output req, mode0, mode1, dev0, dev1, reg0, reg1, wdata0, wdata1,
    output i2c_xfer_done, i2c_read_data,
    input  gnt, done, err, rdata, busy,
    input  i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data
  );
endinterface

// File: rtl/i2c_done_sync.sv
// Brings the master's completion flag into clk_12m: two synchronizer flops,
// then a registered rising-edge detect producing a one-cycle event.
module i2c_done_sync (
  input  logic clk_12m,
  input  logic rst_n,
  input  logic i_async,
  output logic o_evt
);

  logic [2:0] r_sync;
  logic       r_evt;

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b000;
      r_evt  <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
      r_evt  <= r_sync[1] & ~r_sync[2];
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for the I2C master core: loads one
// request, waits for completion or timeout, then holds a config guard gap.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEFAULT
) (
  input  logic               clk_12m,
  input  logic               rst_n,
  i2c_req_arbiter_if.slave   bus,
  output arb_state_e         o_state
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  arb_state_e  r_state, w_next;
  logic        r_sel, r_last, r_err;
  logic [7:0]  r_mode, r_reg, r_wdata, r_rdata;
  logic [6:0]  r_dev;
  logic [CW-1:0] r_cnt;
  logic        w_evt, w_win, w_timeout, w_guard_done, w_done_cyc;
  logic [7:0]  w_mode_sel;

  i2c_done_sync u_sync (
    .clk_12m (clk_12m),
    .rst_n   (rst_n),
    .i_async (bus.i2c_xfer_done),
    .o_evt   (w_evt)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_win = 1'b0;
    case (bus.req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  assign w_mode_sel   = w_win ? bus.mode1 : bus.mode0;
  assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_guard_done = (r_cnt == CW'(GUARD_CYCLES - 1));
  assign w_done_cyc   = (r_state == ST_CLEAR) && (r_cnt == '0);

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req != 2'b00) w_next = ST_LOAD;
      ST_LOAD: begin
        if (bus.req == 2'b00)            w_next = ST_IDLE;
        else if (mode_valid(w_mode_sel)) w_next = ST_WAIT;
        else                             w_next = ST_CLEAR;
      end
      ST_WAIT:  if (w_evt || w_timeout) w_next = ST_CLEAR;
      ST_CLEAR: if (w_guard_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_mode  <= 8'h00;
      r_dev   <= 7'h00;
      r_reg   <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_cnt   <= '0;
    end else begin
      // One counter serves both the WAIT timeout and the CLEAR guard gap.
      if (r_state != w_next)
        r_cnt <= '0;
      else if (r_state == ST_WAIT || r_state == ST_CLEAR)
        r_cnt <= r_cnt + CW'(1);

      if (r_state == ST_LOAD && bus.req != 2'b00) begin
        r_sel   <= w_win;
        r_mode  <= w_mode_sel;
        r_dev   <= w_win ? bus.dev1   : bus.dev0;
        r_reg   <= w_win ? bus.reg1   : bus.reg0;
        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
        r_err   <= ~mode_valid(w_mode_sel);
      end

      if (r_state == ST_WAIT) begin
        if (w_evt) begin
          r_err <= 1'b0;
          if (mode_is_read(r_mode)) r_rdata <= bus.i2c_read_data;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end

      if (w_done_cyc) r_last <= r_sel;
    end
  end

  always_comb begin
    bus.gnt        = 2'b00;
    bus.done       = 2'b00;
    bus.err        = 1'b0;
    bus.i2c_config = 8'h00;
    bus.busy       = (r_state != ST_IDLE);
    if (r_state == ST_WAIT) begin
      bus.gnt        = {r_sel, ~r_sel};
      bus.i2c_config = r_mode;
    end
    if (w_done_cyc) begin
      bus.done = {r_sel, ~r_sel};
      bus.err  = r_err;
    end
  end

  assign bus.rdata        = r_rdata;
  assign bus.i2c_dev_addr = r_dev;
  assign bus.i2c_reg_addr = r_reg;
  assign bus.i2c_reg_data = r_wdata;
  assign o_state          = r_state;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: a transaction-level model predicts the
// completion order and results; a negedge monitor checks every done pulse.
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int TMO = 200;
  localparam int GRD = 4;
  localparam int W   = 11;

  logic       clk_12m = 1'b0;
  logic       rst_n;
  arb_state_e dbg_state;

  i2c_req_arbiter_if bus();

  i2c_req_arbiter #(.TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GRD)) dut (
    .clk_12m (clk_12m),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #41 clk_12m = ~clk_12m;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // Reference model state: last requester served and current rdata register.
  logic       m_last;
  logic [7:0] m_rdata;

  // Planned transaction per requester.
  logic [7:0] p_mode [2];
  logic [6:0] p_dev  [2];
  logic [7:0] p_reg  [2];
  logic [7:0] p_wd   [2];
  logic [7:0] p_rdat [2];
  bit         p_tmo  [2];
  bit         p_drop [2];

  logic [7:0] bad_modes [4] = '{8'h00, 8'h07, 8'h80, 8'hFF};

  int zero_run  = 0;
  bit seen_xfer = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every done pulse pops one expectation; also checks the guard gap.
  always @(negedge clk_12m) begin
    if (!rst_n) begin
      seen_xfer = 1'b0;
      zero_run  = 0;
    end else begin
      if (bus.done != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=%b expected no pulse", bus.done);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_vec", bus.done, mon_e[10:9]);
          check("err", bus.err, mon_e[8]);
          check("rdata", bus.rdata, mon_e[7:0]);
        end
      end
      if (bus.i2c_config != 8'h00) begin
        if (seen_xfer && zero_run > 0) check_range("guard_gap", zero_run, GRD, 1000000);
        seen_xfer = 1'b1;
        zero_run  = 0;
      end else begin
        zero_run++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_12m);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.req           = 2'b00;
    bus.i2c_xfer_done = 1'b0;
    bus.i2c_read_data = 8'h00;
    tick(2);
    rst_n   = 1'b1;
    exp_q.delete();
    m_last  = 1'b1;
    m_rdata = 8'h00;
    tick(1);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_12m);
      if (bus.gnt != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int bound, output bit ok, output int cyc, output bit saw_cfg);
    ok = 1'b0;
    cyc = 0;
    saw_cfg = 1'b0;
    while (!ok && cyc < bound) begin
      @(negedge clk_12m);
      cyc++;
      if (cyc == 2) bus.i2c_xfer_done = 1'b0;
      if (bus.i2c_config != 8'h00) saw_cfg = 1'b1;
      if (bus.done != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic serve(input bit g, input bit from_idle);
    bit         ok, saw_cfg, valid, e_err;
    int         cyc;
    logic [7:0] m;
    m     = p_mode[g];
    valid = (m >= 8'h01) && (m <= 8'h06);
    if (!valid || p_tmo[g]) begin
      e_err = 1'b1;
    end else begin
      e_err = 1'b0;
      if (m >= 8'h04) m_rdata = p_rdat[g];
    end
    exp_q.push_back({(g ? 2'b10 : 2'b01), e_err, m_rdata});
    m_last = g;
    if (valid) begin
      wait_gnt(ok);
      check("gnt_seen", ok, 1'b1);
      if (ok) begin
        check("gnt", bus.gnt, (g ? 2'b10 : 2'b01));
        check("cfg", bus.i2c_config, m);
        check("dev", bus.i2c_dev_addr, p_dev[g]);
        check("reg", bus.i2c_reg_addr, p_reg[g]);
        check("wdata", bus.i2c_reg_data, p_wd[g]);
        if (p_drop[g]) bus.req[g] = 1'b0;
        if (p_tmo[g]) begin
          wait_done(TMO + 20, ok, cyc, saw_cfg);
          check("done_seen", ok, 1'b1);
          check_range("timeout_lat", cyc, TMO, TMO);
        end else begin
          tick($urandom_range(0, 4));
          bus.i2c_read_data = p_rdat[g];
          bus.i2c_xfer_done = 1'b1;
          wait_done(20, ok, cyc, saw_cfg);
          check("done_seen", ok, 1'b1);
          check_range("done_lat", cyc, 3, 4);
        end
      end
    end else begin
      wait_done(20, ok, cyc, saw_cfg);
      check("done_seen", ok, 1'b1);
      check("badmode_cfg", saw_cfg, 1'b0);
      check_range("badmode_lat", cyc, 1, from_idle ? 3 : 20);
    end
    bus.req[g] = 1'b0;
  endtask

  task automatic run_pat(input logic [1:0] pat);
    bit first;
    for (int i = 0; i < 20 && bus.busy; i++) tick(1);
    bus.mode0 = p_mode[0]; bus.dev0 = p_dev[0]; bus.reg0 = p_reg[0]; bus.wdata0 = p_wd[0];
    bus.mode1 = p_mode[1]; bus.dev1 = p_dev[1]; bus.reg1 = p_reg[1]; bus.wdata1 = p_wd[1];
    bus.req = pat;
    if (pat == 2'b11) begin
      first = ~m_last;
      serve(first, 1'b1);
      serve(~first, 1'b0);
    end else begin
      serve(pat[1], 1'b1);
    end
    tick(1);
  endtask

  task automatic plan(input bit g, input logic [7:0] mode, input logic [6:0] dev,
                      input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rd,
                      input bit tmo, input bit drop);
    p_mode[g] = mode; p_dev[g] = dev; p_reg[g] = rg; p_wd[g] = wd;
    p_rdat[g] = rd;   p_tmo[g] = tmo; p_drop[g] = drop;
  endtask

  initial begin
    bit ok;
    do_reset();
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_outs", {bus.gnt, bus.done, bus.err, bus.busy, bus.rdata, bus.i2c_config,
                         bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data}, 64'h0);

    // Single write from requester 0.
    plan(0, 8'h01, 7'h50, 8'h00, 8'h11, 8'h00, 0, 0);
    plan(1, 8'h01, 7'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    run_pat(2'b01);

    // Tie from reset: requester 0 first, then requester 1.
    do_reset();
    plan(0, 8'h04, 7'h21, 8'h10, 8'h00, 8'hAA, 0, 0);
    plan(1, 8'h04, 7'h22, 8'h20, 8'h00, 8'h55, 0, 0);
    run_pat(2'b11);

    // Bad mode on requester 1.
    plan(1, 8'h07, 7'h33, 8'h01, 8'h02, 8'h00, 0, 0);
    run_pat(2'b10);

    // Read that never completes: timeout, rdata unchanged.
    plan(0, 8'h04, 7'h44, 8'h05, 8'h06, 8'hC3, 1, 0);
    run_pat(2'b01);

    // Reset during WAIT abandons the transfer.
    for (int i = 0; i < 20 && bus.busy; i++) tick(1);
    plan(0, 8'h01, 7'h12, 8'h34, 8'h56, 8'h00, 0, 0);
    bus.mode0 = p_mode[0]; bus.dev0 = p_dev[0]; bus.reg0 = p_reg[0]; bus.wdata0 = p_wd[0];
    bus.req = 2'b01;
    wait_gnt(ok);
    check("pre_reset_gnt", ok, 1'b1);
    #5 rst_n = 1'b0;
    #1 check("midreset_outs", {bus.gnt, bus.done, bus.err, bus.busy, bus.rdata, bus.i2c_config,
                               bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_reg_data}, 64'h0);
    check("midreset_state", dbg_state, ST_IDLE);
    do_reset();
    tick(10);
    run_pat(2'b01);

    // Master edge while idle is ignored; dropped req in WAIT still completes.
    bus.i2c_read_data = 8'h99;
    bus.i2c_xfer_done = 1'b1;
    tick(2);
    bus.i2c_xfer_done = 1'b0;
    tick(6);
    check("idle_evt_busy", bus.busy, 1'b0);
    plan(0, 8'h05, 7'h0F, 8'h0E, 8'h0D, 8'h3C, 0, 1);
    run_pat(2'b01);

    for (int it = 0; it < 40; it++) begin
      for (int g = 0; g < 2; g++) begin
        plan(g[0], ($urandom_range(0, 7) == 0) ? bad_modes[$urandom_range(0, 3)]
                                               : 8'($urandom_range(1, 6)),
             7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
      end
      run_pat(2'($urandom_range(1, 3)));
    end

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

endmodule
